hw_barrier_initiator: RTL and testbench
=======================================

Name: hw_barrier_initiator

Overview:
- Core-side initiator for the hardware barrier peripheral: turns local barrier commands into XBAR_PERIPH_BUS-style master transactions (req/gnt, delayed r_valid).
- Supported operations: program trigger/target masks, arrive, arrive-and-wait on the barrier event line, read barrier status.
- Sits between a core or DMA-side controller and the peripheral interconnect port of the barrier unit.
- Exactly one bus transaction outstanding at a time.

Parameters:
NB_CORES, 4, width of all mask/status fields
CORE_ID, 0, bit index this initiator sets on arrive (0..NB_CORES-1)
BASE_ADDR, 32'h0000_0000, barrier register base; register offsets are add[4:2] = 0 trigger mask, 1 status, 3 target mask, 4 trigger
TIMEOUT, 0, max cycles in WAIT_EVT before error; 0 disables timeout

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_op_i  in  2  00 CONFIG, 01 ARRIVE, 10 ARRIVE_WAIT, 11 READ_STATUS
cmd_trig_mask_i  in  NB_CORES  trigger mask for CONFIG
cmd_tgt_mask_i  in  NB_CORES  target mask for CONFIG
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&ready
rsp_data_o  out  NB_CORES  status for READ_STATUS, else 0
rsp_err_o  out  1  ARRIVE_WAIT timed out
bus_req_o  out  1  bus request
bus_add_o  out  32  BASE_ADDR + offset*4
bus_wen_o  out  1  1 = read, 0 = write
bus_wdata_o  out  32  write data, zero-extended from NB_CORES
bus_be_o  out  4  always 4'hF when req
bus_gnt_i  in  1  grant
bus_r_valid_i  in  1  response valid, one or more cycles after gnt
bus_r_rdata_i  in  32  read data
barrier_event_i  in  1  barrier event for this core from the event matrix

Behaviour:
- Reset: state IDLE. cmd_ready_o=1. rsp_valid_o=0, rsp_err_o=0, rsp_data_o=0. bus_req_o=0; bus_add_o, bus_wdata_o, bus_wen_o, bus_be_o all 0. Event flag and timeout counter cleared.
- Reset mid-transaction: req drops immediately. No retry after reset.
- cmd_ready_o=1 only in IDLE. A command is accepted on valid&ready; its op and masks are registered.
- Bus handshake:
  - req, add, wen, wdata held stable from the cycle req rises until the cycle gnt=1.
  - req deasserts the cycle after gnt.
  - The FSM then waits for bus_r_valid_i (writes included) before the next step.
  - r_valid seen without an outstanding grant is ignored.
- States: IDLE, WR_TMASK, WR_GMASK, WR_TRIG, RD_STAT, WAIT_RSP, WAIT_EVT, RESP.
  - CONFIG: WR_TMASK (off 0, trig mask) -> WAIT_RSP -> WR_GMASK (off 3, tgt mask) -> WAIT_RSP -> RESP.
  - ARRIVE: WR_TRIG (off 4, wdata = 1<<CORE_ID) -> WAIT_RSP -> RESP.
  - ARRIVE_WAIT: WR_TRIG -> WAIT_RSP -> WAIT_EVT -> RESP.
  - READ_STATUS: RD_STAT (off 1, wen=1) -> WAIT_RSP -> RESP. rsp_data_o = r_rdata[NB_CORES-1:0], captured on r_valid.
- Event capture (ARRIVE_WAIT):
  - Sticky evt flag cleared on the trigger write's gnt cycle; set by barrier_event_i in any later cycle.
  - The event may coincide with or precede the write's r_valid; it must not be lost.
  - Events at or before the gnt cycle belong to a prior barrier and are ignored.
  - WAIT_EVT -> RESP on the first cycle evt flag or barrier_event_i is 1.
- Timeout:
  - Counter starts at 0 on entry to WAIT_EVT.
  - If TIMEOUT>0 and the counter reaches TIMEOUT with no event, go to RESP with rsp_err_o=1.
  - An event on the same cycle as timeout wins (err=0).
- RESP: rsp_valid_o=1 held until rsp_ready_i; then IDLE with rsp_valid_o, rsp_err_o, rsp_data_o cleared.
- Latency: minimal ARRIVE with gnt same cycle and r_valid next cycle gives rsp_valid 3 cycles after command accept.
- No cmd_valid_i while busy is queued; the source must wait for cmd_ready_o.

Test Plan:
- CONFIG trig=4'b0011, tgt=4'b0011, gnt immediate -> writes add=BASE+0x0 wdata=3, then BASE+0xC wdata=3, each held until gnt; one rsp_valid, err=0.
- ARRIVE with gnt stalled 5 cycles, CORE_ID=2 -> req/add/wdata=4'b0100 stable all 5 cycles; req low the cycle after gnt; rsp after r_valid.
- ARRIVE_WAIT, barrier_event_i pulsed 1 cycle in the same cycle as r_valid -> event captured; rsp err=0 without waiting further.
- ARRIVE_WAIT, event pulsed one cycle before gnt and not again, TIMEOUT=8 -> early pulse ignored; rsp_err_o=1 exactly 8 cycles after WAIT_EVT entry.
- READ_STATUS, r_rdata=32'hFFFF_FFF5 -> rsp_data_o=4'b0101, wen=1, add=BASE+0x4; rsp held under rsp_ready_i=0 for 3 cycles.
- rst_ni asserted while req high awaiting gnt -> req and all outputs 0 asynchronously; after release cmd_ready_o=1 and a new ARRIVE completes normally.

Source files
------------

// File: rtl/hw_barrier_initiator_if.sv
// Purpose : peripheral-bus link between the barrier initiator and the barrier unit
//           (req/gnt request phase, one or more cycles later an r_valid response phase).
// Ports   : master drives req/add/wen/wdata/be, slave returns gnt/r_valid/r_rdata.
interface hw_barrier_initiator_if;
  logic        req;
  logic [31:0] add;
  logic        wen;      // 1 = read, 0 = write
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        gnt;
  logic        r_valid;
  logic [31:0] r_rdata;

  modport master (
    output req, add, wen, wdata, be,
    input  gnt, r_valid, r_rdata
  );

  modport slave (
    input  req, add, wen, wdata, be,
    output gnt, r_valid, r_rdata
  );
endinterface

// File: rtl/hw_barrier_initiator.sv
// Purpose : core-side barrier initiator; turns CONFIG / ARRIVE / ARRIVE_WAIT / READ_STATUS
//           commands into single-outstanding peripheral-bus transactions.
// Latency : minimal ARRIVE (gnt same cycle, r_valid next cycle) -> rsp_valid 3 cycles after accept.
// Backpr. : cmd_ready only in IDLE; request held until gnt; response held until rsp_ready.
// Ports   : clk_i/rst_ni; cmd_* command handshake; rsp_* response handshake;
//           bus (master modport) peripheral request/response; barrier_event_i event line.
module hw_barrier_initiator #(
  parameter int unsigned NB_CORES  = 4,
  parameter int unsigned CORE_ID   = 0,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [1:0]          cmd_op_i,
  input  logic [NB_CORES-1:0] cmd_trig_mask_i,
  input  logic [NB_CORES-1:0] cmd_tgt_mask_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [NB_CORES-1:0] rsp_data_o,
  output logic                rsp_err_o,
  hw_barrier_initiator_if.master bus,
  input  logic                barrier_event_i
);

  localparam logic [1:0] OP_CONFIG      = 2'b00;
  localparam logic [1:0] OP_ARRIVE      = 2'b01;
  localparam logic [1:0] OP_ARRIVE_WAIT = 2'b10;
  localparam logic [1:0] OP_READ_STATUS = 2'b11;

  localparam logic [31:0] ADDR_TMASK  = BASE_ADDR + 32'h0000_0000;
  localparam logic [31:0] ADDR_STATUS = BASE_ADDR + 32'h0000_0004;
  localparam logic [31:0] ADDR_GMASK  = BASE_ADDR + 32'h0000_000C;
  localparam logic [31:0] ADDR_TRIG   = BASE_ADDR + 32'h0000_0010;
  localparam logic [31:0] TRIG_WDATA  = 32'd1 << CORE_ID;

  // Counter only has to reach TIMEOUT-1: the timeout fires on the edge where it would hit TIMEOUT.
  localparam int unsigned         CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, WR_TMASK, WR_GMASK, WR_TRIG, RD_STAT, WAIT_RSP, WAIT_EVT, RESP
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          op_q;
  logic [NB_CORES-1:0] trig_q, tgt_q;
  logic                second_q;     // CONFIG: target-mask write already granted
  logic                evt_q;        // sticky barrier event for the current trigger
  logic [CNT_W-1:0]    cnt_q;
  logic [NB_CORES-1:0] rsp_data_q;
  logic                rsp_err_q;

  logic accept;
  logic evt_now;
  logic timeout_hit;
  logic unused_rdata_hi;

  assign accept          = cmd_valid_i && (state_q == IDLE);
  assign evt_now         = evt_q || barrier_event_i;
  assign timeout_hit     = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
  assign unused_rdata_hi = ^bus.r_rdata[31:NB_CORES];

  assign cmd_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          unique case (cmd_op_i)
            OP_CONFIG:      state_d = WR_TMASK;
            OP_ARRIVE:      state_d = WR_TRIG;
            OP_ARRIVE_WAIT: state_d = WR_TRIG;
            OP_READ_STATUS: state_d = RD_STAT;
            default:        state_d = IDLE;
          endcase
        end
      end
      WR_TMASK, WR_GMASK, WR_TRIG, RD_STAT: begin
        if (bus.gnt) state_d = WAIT_RSP;
      end
      // Only reachable after a grant, so a stray r_valid elsewhere is ignored.
      WAIT_RSP: begin
        if (bus.r_valid) begin
          if (op_q == OP_CONFIG)           state_d = second_q ? RESP : WR_GMASK;
          else if (op_q == OP_ARRIVE_WAIT) state_d = WAIT_EVT;
          else                             state_d = RESP;
        end
      end
      // A live event wins over a simultaneous timeout.
      WAIT_EVT: begin
        if (evt_now || timeout_hit) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request phase is decoded from the state, so the address/data stay stable until gnt
  // and req drops the moment reset is asserted.
  always_comb begin
    bus.req   = 1'b0;
    bus.add   = '0;
    bus.wen   = 1'b0;
    bus.wdata = '0;
    bus.be    = '0;
    case (state_q)
      WR_TMASK: begin
        bus.req   = 1'b1;
        bus.add   = ADDR_TMASK;
        bus.wdata = 32'(trig_q);
        bus.be    = 4'hF;
      end
      WR_GMASK: begin
        bus.req   = 1'b1;
        bus.add   = ADDR_GMASK;
        bus.wdata = 32'(tgt_q);
        bus.be    = 4'hF;
      end
      WR_TRIG: begin
        bus.req   = 1'b1;
        bus.add   = ADDR_TRIG;
        bus.wdata = TRIG_WDATA;
        bus.be    = 4'hF;
      end
      RD_STAT: begin
        bus.req   = 1'b1;
        bus.add   = ADDR_STATUS;
        bus.wen   = 1'b1;
        bus.be    = 4'hF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q       <= OP_CONFIG;
      trig_q     <= '0;
      tgt_q      <= '0;
      second_q   <= 1'b0;
      evt_q      <= 1'b0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q     <= cmd_op_i;
        trig_q   <= cmd_trig_mask_i;
        tgt_q    <= cmd_tgt_mask_i;
        second_q <= 1'b0;
      end

      if (state_q == WR_GMASK && bus.gnt) second_q <= 1'b1;

      // Events up to and including the trigger grant belong to an earlier barrier.
      if (state_q == WR_TRIG && bus.gnt) evt_q <= 1'b0;
      else if (barrier_event_i)          evt_q <= 1'b1;

      if (state_q == WAIT_EVT) cnt_q <= cnt_q + CNT_W'(1);
      else                     cnt_q <= '0;

      if (state_q == WAIT_RSP && bus.r_valid && op_q == OP_READ_STATUS)
        rsp_data_q <= bus.r_rdata[NB_CORES-1:0];

      if (state_q == WAIT_EVT && !evt_now && timeout_hit)
        rsp_err_q <= 1'b1;

      if (state_q == RESP && rsp_ready_i) begin
        rsp_data_q <= '0;
        rsp_err_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hw_barrier_initiator.sv
// Purpose : self-checking bench for hw_barrier_initiator (CORE_ID=2, TIMEOUT=8).
// Latency : directed, cycle-exact expectations.
// Backpr. : bench acts as the bus slave and response consumer.
module tb_hw_barrier_initiator;

  localparam logic [31:0] BASE = 32'h4000_1000;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       cmd_valid_i = 1'b0;
  logic       cmd_ready_o;
  logic [1:0] cmd_op_i = 2'b00;
  logic [3:0] cmd_trig_mask_i = '0;
  logic [3:0] cmd_tgt_mask_i = '0;
  logic       rsp_valid_o;
  logic       rsp_ready_i = 1'b0;
  logic [3:0] rsp_data_o;
  logic       rsp_err_o;
  logic       barrier_event_i = 1'b0;

  hw_barrier_initiator_if bus_if ();

  hw_barrier_initiator #(
    .NB_CORES (4),
    .CORE_ID  (2),
    .BASE_ADDR(BASE),
    .TIMEOUT  (8)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_op_i       (cmd_op_i),
    .cmd_trig_mask_i(cmd_trig_mask_i),
    .cmd_tgt_mask_i (cmd_tgt_mask_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_data_o     (rsp_data_o),
    .rsp_err_o      (rsp_err_o),
    .bus            (bus_if),
    .barrier_event_i(barrier_event_i)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  trig;
    logic [3:0]  tgt;
    int          gnt_dly;
    int          rv_dly;
    int          hold;
    logic [31:0] rdata;
    int          nbeats;
    logic [31:0] add0, wd0, add1, wd1;
    logic        wen;
    logic [3:0]  exp_data;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic release_rsp(input string tag);
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    check({tag, " rsp_valid cleared"}, 32'(rsp_valid_o), 32'd0);
    check({tag, " rsp_err cleared"},   32'(rsp_err_o),   32'd0);
    check({tag, " cmd_ready back"},    32'(cmd_ready_o), 32'd1);
  endtask

  task automatic start_cmd(input string tag, input logic [1:0] op,
                           input logic [3:0] trig, input logic [3:0] tgt);
    check({tag, " cmd_ready"}, 32'(cmd_ready_o), 32'd1);
    cmd_valid_i = 1'b1;
    cmd_op_i = op;
    cmd_trig_mask_i = trig;
    cmd_tgt_mask_i = tgt;
    step();
    cmd_valid_i = 1'b0;
    cmd_trig_mask_i = '0;
    cmd_tgt_mask_i = '0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string       t;
    logic [31:0] ea, ew;
    t = $sformatf("v%0d", idx);
    start_cmd(t, v.op, v.trig, v.tgt);
    for (int b = 0; b < v.nbeats; b++) begin
      ea = (b == 0) ? v.add0 : v.add1;
      ew = (b == 0) ? v.wd0 : v.wd1;
      for (int d = 0; d <= v.gnt_dly; d++) begin
        bus_if.gnt = (d == v.gnt_dly);
        // r_valid without an outstanding grant must be ignored
        bus_if.r_valid = (d == 0) && (v.gnt_dly > 0);
        bus_if.r_rdata = 32'hBAD0_BAD0;
        #1;
        check($sformatf("%s b%0d d%0d req", t, b, d),   32'(bus_if.req), 32'd1);
        check($sformatf("%s b%0d d%0d add", t, b, d),   bus_if.add, ea);
        check($sformatf("%s b%0d d%0d wdata", t, b, d), bus_if.wdata, ew);
        check($sformatf("%s b%0d d%0d wen", t, b, d),   32'(bus_if.wen), 32'(v.wen));
        check($sformatf("%s b%0d d%0d be", t, b, d),    32'(bus_if.be), 32'hF);
        check($sformatf("%s b%0d d%0d cmd_ready", t, b, d), 32'(cmd_ready_o), 32'd0);
        step();
      end
      bus_if.gnt = 1'b0;
      bus_if.r_valid = 1'b0;
      check($sformatf("%s b%0d req low after gnt", t, b), 32'(bus_if.req), 32'd0);
      for (int d = 0; d < v.rv_dly; d++) begin
        check($sformatf("%s b%0d rsp early", t, b), 32'(rsp_valid_o), 32'd0);
        step();
      end
      bus_if.r_valid = 1'b1;
      bus_if.r_rdata = v.rdata;
      step();
      bus_if.r_valid = 1'b0;
      bus_if.r_rdata = '0;
    end
    check({t, " rsp_valid"}, 32'(rsp_valid_o), 32'd1);
    check({t, " rsp_data"},  32'(rsp_data_o),  32'(v.exp_data));
    check({t, " rsp_err"},   32'(rsp_err_o),   32'd0);
    for (int h = 0; h < v.hold; h++) begin
      step();
      check($sformatf("%s hold%0d rsp_valid", t, h), 32'(rsp_valid_o), 32'd1);
      check($sformatf("%s hold%0d rsp_data", t, h),  32'(rsp_data_o),  32'(v.exp_data));
    end
    release_rsp(t);
  endtask

  // ARRIVE_WAIT up to WAIT_EVT entry; optional early event one cycle before gnt.
  task automatic arrive_wait_to_evt(input string tag, input logic early_evt);
    start_cmd(tag, 2'b10, 4'h0, 4'h0);
    barrier_event_i = early_evt;
    bus_if.gnt = 1'b0;
    step();
    barrier_event_i = 1'b0;
    bus_if.gnt = 1'b1;
    #1;
    check({tag, " trig add"},   bus_if.add,   BASE + 32'h10);
    check({tag, " trig wdata"}, bus_if.wdata, 32'h4);
    step();
    bus_if.gnt = 1'b0;
    bus_if.r_valid = 1'b1;
    step();
    bus_if.r_valid = 1'b0;
  endtask

  initial begin
    bus_if.gnt = 1'b0;
    bus_if.r_valid = 1'b0;
    bus_if.r_rdata = '0;

    vecs[0] = '{op:2'b00, trig:4'b0011, tgt:4'b0011, gnt_dly:0, rv_dly:0, hold:0,
                rdata:32'hDEAD_BEEF, nbeats:2, add0:BASE, wd0:32'h3,
                add1:BASE + 32'hC, wd1:32'h3, wen:1'b0, exp_data:4'h0};
    vecs[1] = '{op:2'b01, trig:4'h0, tgt:4'h0, gnt_dly:5, rv_dly:2, hold:1,
                rdata:32'hFFFF_FFFF, nbeats:1, add0:BASE + 32'h10, wd0:32'h4,
                add1:32'h0, wd1:32'h0, wen:1'b0, exp_data:4'h0};
    vecs[2] = '{op:2'b11, trig:4'h0, tgt:4'h0, gnt_dly:0, rv_dly:0, hold:3,
                rdata:32'hFFFF_FFF5, nbeats:1, add0:BASE + 32'h4, wd0:32'h0,
                add1:32'h0, wd1:32'h0, wen:1'b1, exp_data:4'b0101};
    vecs[3] = '{op:2'b00, trig:4'b1010, tgt:4'b0110, gnt_dly:2, rv_dly:1, hold:0,
                rdata:32'hFFFF_FFFF, nbeats:2, add0:BASE, wd0:32'hA,
                add1:BASE + 32'hC, wd1:32'h6, wen:1'b0, exp_data:4'h0};
    vecs[4] = '{op:2'b11, trig:4'h0, tgt:4'h0, gnt_dly:1, rv_dly:3, hold:1,
                rdata:32'h0000_000A, nbeats:1, add0:BASE + 32'h4, wd0:32'h0,
                add1:32'h0, wd1:32'h0, wen:1'b1, exp_data:4'hA};

    // Reset state
    #2;
    check("reset cmd_ready", 32'(cmd_ready_o), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("reset rsp_err",   32'(rsp_err_o),   32'd0);
    check("reset rsp_data",  32'(rsp_data_o),  32'd0);
    check("reset req",       32'(bus_if.req),  32'd0);
    check("reset add",       bus_if.add,       32'd0);
    check("reset wdata",     bus_if.wdata,     32'd0);
    check("reset wen",       32'(bus_if.wen),  32'd0);
    check("reset be",        32'(bus_if.be),   32'd0);
    step();
    step();
    #2;
    rst_ni = 1'b1;
    step();

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Minimal ARRIVE latency: rsp_valid 3 cycles after accept
    start_cmd("lat", 2'b01, 4'h0, 4'h0);
    bus_if.gnt = 1'b1;
    #1;
    check("lat req", 32'(bus_if.req), 32'd1);
    step();
    bus_if.gnt = 1'b0;
    bus_if.r_valid = 1'b1;
    check("lat rsp not yet", 32'(rsp_valid_o), 32'd0);
    step();
    bus_if.r_valid = 1'b0;
    check("lat rsp_valid", 32'(rsp_valid_o), 32'd1);
    release_rsp("lat");

    // ARRIVE_WAIT: event pulse coincides with the write's r_valid
    start_cmd("aw_coinc", 2'b10, 4'h0, 4'h0);
    bus_if.gnt = 1'b1;
    step();
    bus_if.gnt = 1'b0;
    bus_if.r_valid = 1'b1;
    barrier_event_i = 1'b1;
    step();
    bus_if.r_valid = 1'b0;
    barrier_event_i = 1'b0;
    check("aw_coinc wait_evt", 32'(rsp_valid_o), 32'd0);
    step();
    check("aw_coinc rsp_valid", 32'(rsp_valid_o), 32'd1);
    check("aw_coinc rsp_err",   32'(rsp_err_o),   32'd0);
    release_rsp("aw_coinc");

    // ARRIVE_WAIT: stale event before gnt ignored -> timeout 8 cycles after WAIT_EVT entry
    arrive_wait_to_evt("aw_to", 1'b1);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("aw_to c%0d no rsp", k), 32'(rsp_valid_o), 32'd0);
      step();
    end
    check("aw_to rsp_valid", 32'(rsp_valid_o), 32'd1);
    check("aw_to rsp_err",   32'(rsp_err_o),   32'd1);
    step();
    check("aw_to err held", 32'(rsp_err_o), 32'd1);
    release_rsp("aw_to");

    // ARRIVE_WAIT: event on the timeout cycle wins
    arrive_wait_to_evt("aw_tie", 1'b0);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("aw_tie c%0d no rsp", k), 32'(rsp_valid_o), 32'd0);
      barrier_event_i = (k == 7);
      step();
      barrier_event_i = 1'b0;
    end
    check("aw_tie rsp_valid", 32'(rsp_valid_o), 32'd1);
    check("aw_tie rsp_err",   32'(rsp_err_o),   32'd0);
    release_rsp("aw_tie");

    // ARRIVE_WAIT: live event mid-wait
    arrive_wait_to_evt("aw_mid", 1'b0);
    step();
    step();
    barrier_event_i = 1'b1;
    step();
    barrier_event_i = 1'b0;
    check("aw_mid rsp_valid", 32'(rsp_valid_o), 32'd1);
    check("aw_mid rsp_err",   32'(rsp_err_o),   32'd0);
    release_rsp("aw_mid");

    // Reset while req is waiting for gnt
    start_cmd("rst", 2'b01, 4'h0, 4'h0);
    check("rst req before", 32'(bus_if.req), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst req async",   32'(bus_if.req),  32'd0);
    check("rst add async",   bus_if.add,       32'd0);
    check("rst wdata async", bus_if.wdata,     32'd0);
    check("rst be async",    32'(bus_if.be),   32'd0);
    check("rst wen async",   32'(bus_if.wen),  32'd0);
    check("rst rsp_valid",   32'(rsp_valid_o), 32'd0);
    step();
    #2;
    rst_ni = 1'b1;
    step();
    check("rst no retry req", 32'(bus_if.req), 32'd0);
    check("rst cmd_ready",    32'(cmd_ready_o), 32'd1);
    run_vec(vecs[1], 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
